// File: rtl/apb_uart_rx_fifo_slave.sv
// apb_uart_rx_fifo_slave
//   APB register slave for the UART receiver. A receive FIFO of
//   FIFO_DEPTH bytes sits between the receiver and the bus, sticky
//   error flags are cleared by writing 1, and writes are validated
//   with pslverr.
//   Optional feature macro: UART_RX_IRQ_EN (address 7 becomes the
//   interrupt enable register and irq is driven; otherwise irq is 0).
module apb_uart_rx_fifo_slave #(
    parameter int  FIFO_DEPTH = 8,
    parameter int  BP_W       = 14,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      rx_data,
    input  logic            data_ready,
    input  logic            overrun_error,
    input  logic            framing_error,
    input  logic            psel,
    input  logic [2:0]      paddr,
    input  logic            penable,
    input  logic            pwrite,
    input  logic [7:0]      pwdata,
    output logic [7:0]      prdata,
    output logic            pslverr,
    output logic            data_read,
    output logic [3:0]      data_size,
    output logic [BP_W-1:0] bit_period,
    output logic            irq
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int HI_W  = BP_W - 8;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] ADDR_STATUS = 3'd0;
    localparam logic [2:0] ADDR_ERRS   = 3'd1;
    localparam logic [2:0] ADDR_BP_LO  = 3'd2;
    localparam logic [2:0] ADDR_BP_HI  = 3'd3;
    localparam logic [2:0] ADDR_DSIZE  = 3'd4;
    localparam logic [2:0] ADDR_COUNT  = 3'd5;
    localparam logic [2:0] ADDR_HEAD   = 3'd6;
`ifdef UART_RX_IRQ_EN
    localparam logic [2:0] ADDR_IRQEN  = 3'd7;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [2:0]       r_err;
    logic [BP_W-1:0]  r_bit_period;
    logic [3:0]       r_data_size;
    logic             r_data_read;
    logic             r_dr_prev;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic             w_access;
    logic             w_wr;
    logic             w_rd;
    logic             w_not_empty;
    logic             w_full;
    logic             w_push_req;
    logic             w_pop;
    logic             w_push_ok;
    logic             w_overflow;
    logic             w_dsize_legal;
    logic [2:0]       w_err_clr;
    logic [2:0]       w_err_set;
    logic [CNT_W-1:0] w_count_nxt;
    logic [7:0]       w_bp_hi_rd;
    logic [7:0]       w_rdata;
    logic             w_slverr;

    assign w_access    = psel & penable;
    assign w_wr        = w_access & pwrite;
    assign w_rd        = w_access & ~pwrite;
    assign w_not_empty = (r_count != {CNT_W{1'b0}});
    assign w_full      = (r_count == FULL_CNT);

    // A new byte is offered only on the rising edge of data_ready; the
    // receiver holds data_ready high until it sees data_read.
    assign w_push_req  = data_ready & ~r_dr_prev;
    assign w_pop       = w_rd & (paddr == ADDR_HEAD) & w_not_empty;

    // A pop in the same cycle frees a slot, so a push into a full FIFO
    // alongside a pop is accepted rather than counted as overflow.
    assign w_push_ok   = w_push_req & (~w_full | w_pop);
    assign w_overflow  = w_push_req & w_full & ~w_pop;

    assign w_dsize_legal = (pwdata >= 8'd5) && (pwdata <= 8'd8);

    assign w_err_set = {w_overflow, overrun_error, framing_error};
    assign w_err_clr = (w_wr && (paddr == ADDR_ERRS)) ? pwdata[2:0] : 3'b000;

    // Occupancy counter next value: simultaneous push and pop cancel out.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Zero-extend the upper bit_period field for readback.
    always_comb begin
        w_bp_hi_rd = 8'd0;
        if (HI_W > 0) begin
            w_bp_hi_rd[HI_W-1:0] = r_bit_period[BP_W-1:8];
        end else begin
            w_bp_hi_rd = 8'd0;
        end
    end

    // ------------------------------------------------------------------
    // Optional interrupt
    // ------------------------------------------------------------------
`ifdef UART_RX_IRQ_EN
    logic [1:0] r_irq_en;
    logic       r_irq;

    // Interrupt enable register and registered interrupt output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_en <= 2'b00;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr && (paddr == ADDR_IRQEN)) begin
                r_irq_en <= pwdata[1:0];
            end
            r_irq <= (r_irq_en[0] & w_not_empty) | (r_irq_en[1] & (|r_err));
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    // ------------------------------------------------------------------
    // APB read data and slave error (combinational during access phase)
    // ------------------------------------------------------------------

    // Decode the access into prdata/pslverr; both stay 0 when idle.
    always_comb begin
        w_rdata  = 8'd0;
        w_slverr = 1'b0;
        if (w_wr) begin
            case (paddr)
                ADDR_STATUS, ADDR_COUNT, ADDR_HEAD: w_slverr = 1'b1;
                ADDR_DSIZE:                         w_slverr = ~w_dsize_legal;
                ADDR_ERRS, ADDR_BP_LO, ADDR_BP_HI:  w_slverr = 1'b0;
`ifdef UART_RX_IRQ_EN
                ADDR_IRQEN:                         w_slverr = 1'b0;
`endif
                default:                            w_slverr = 1'b1;
            endcase
        end else if (w_rd) begin
            case (paddr)
                ADDR_STATUS: w_rdata = {6'd0, w_full, w_not_empty};
                ADDR_ERRS:   w_rdata = {5'd0, r_err};
                ADDR_BP_LO:  w_rdata = r_bit_period[7:0];
                ADDR_BP_HI:  w_rdata = w_bp_hi_rd;
                ADDR_DSIZE:  w_rdata = {4'd0, r_data_size};
                ADDR_COUNT:  w_rdata = 8'(r_count);
                ADDR_HEAD: begin
                    if (w_not_empty) begin
                        w_rdata = r_mem[r_rptr];
                    end else begin
                        w_rdata  = 8'd0;
                        w_slverr = 1'b1;
                    end
                end
`ifdef UART_RX_IRQ_EN
                ADDR_IRQEN:  w_rdata = {6'd0, r_irq_en};
`endif
                default: begin
                    w_rdata  = 8'd0;
                    w_slverr = 1'b1;
                end
            endcase
        end else begin
            w_rdata  = 8'd0;
            w_slverr = 1'b0;
        end
    end

    assign prdata  = w_rdata;
    assign pslverr = w_slverr;

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // FIFO storage; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= rx_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power of two).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= {PTR_W{1'b0}};
            r_rptr  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // data_ready history and the one-cycle acknowledge back to the receiver.
    // The acknowledge fires even when the byte is dropped on overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dr_prev   <= 1'b0;
            r_data_read <= 1'b0;
        end else begin
            r_dr_prev   <= data_ready;
            r_data_read <= w_push_req;
        end
    end

    // Sticky error flags: a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 3'b000;
        end else begin
            r_err <= (r_err & ~w_err_clr) | w_err_set;
        end
    end

    // Configuration registers driven to the receiver.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_period <= {BP_W{1'b0}};
            r_data_size  <= 4'd8;
        end else begin
            if (w_wr && (paddr == ADDR_BP_LO)) begin
                r_bit_period[7:0] <= pwdata;
            end
            if (w_wr && (paddr == ADDR_BP_HI)) begin
                r_bit_period[BP_W-1:8] <= pwdata[HI_W-1:0];
            end
            if (w_wr && (paddr == ADDR_DSIZE) && w_dsize_legal) begin
                r_data_size <= pwdata[3:0];
            end
        end
    end

    assign data_read  = r_data_read;
    assign data_size  = r_data_size;
    assign bit_period = r_bit_period;

endmodule

// File: tb/tb_apb_uart_rx_fifo_slave.sv
// Directed testbench for apb_uart_rx_fifo_slave (FIFO_DEPTH=8, BP_W=14).
// Define UART_RX_IRQ_EN on both RTL and bench to exercise the interrupt.
module tb_apb_uart_rx_fifo_slave;

    localparam int FIFO_DEPTH = 8;
    localparam int BP_W       = 14;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      rx_data;
    logic            data_ready;
    logic            overrun_error;
    logic            framing_error;
    logic            psel;
    logic [2:0]      paddr;
    logic            penable;
    logic            pwrite;
    logic [7:0]      pwdata;
    logic [7:0]      prdata;
    logic            pslverr;
    logic            data_read;
    logic [3:0]      data_size;
    logic [BP_W-1:0] bit_period;
    logic            irq;

    int n_tests = 0;
    int n_fail  = 0;

    apb_uart_rx_fifo_slave #(.FIFO_DEPTH(FIFO_DEPTH), .BP_W(BP_W)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .data_ready(data_ready),
        .overrun_error(overrun_error), .framing_error(framing_error),
        .psel(psel), .paddr(paddr), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pslverr(pslverr),
        .data_read(data_read), .data_size(data_size),
        .bit_period(bit_period), .irq(irq)
    );

    always #5 clk = ~clk;

    // APB write; returns pslverr sampled mid access phase.
    task automatic apb_write(input logic [2:0] a, input logic [7:0] d, output logic err);
        psel = 1'b1; paddr = a; pwrite = 1'b1; pwdata = d; penable = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk); err = pslverr;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    // APB read; returns prdata and pslverr sampled mid access phase.
    task automatic apb_read(input logic [2:0] a, output logic [7:0] d, output logic err);
        psel = 1'b1; paddr = a; pwrite = 1'b0; penable = 1'b0;
        @(posedge clk); #1 penable = 1'b1;
        @(negedge clk); d = prdata; err = pslverr;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    endtask

    // Offer one byte like the receiver does and count data_read pulses.
    task automatic push_byte(input logic [7:0] b, output int pulses);
        pulses = 0;
        rx_data = b; data_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (data_read) begin
                pulses++;
                data_ready = 1'b0;
            end
        end
        data_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d; logic e;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_tests++; if (bit_period !== 14'd0) begin n_fail++; $display("FAIL reset_bp got %h exp 0", bit_period); end
        n_tests++; if (data_size !== 4'd8) begin n_fail++; $display("FAIL reset_dsize got %0d exp 8", data_size); end
        n_tests++; if (data_read !== 1'b0) begin n_fail++; $display("FAIL reset_data_read got %b exp 0", data_read); end
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b exp 0", irq); end
        n_tests++; if (prdata !== 8'd0 || pslverr !== 1'b0) begin n_fail++; $display("FAIL idle_bus got %h/%b exp 00/0", prdata, pslverr); end
        apb_read(3'd4, d, e);
        n_tests++; if (d !== 8'd8 || e !== 1'b0) begin n_fail++; $display("FAIL reset_rd4 got %h/%b exp 08/0", d, e); end
        apb_read(3'd0, d, e);
        n_tests++; if (d !== 8'd0 || e !== 1'b0) begin n_fail++; $display("FAIL reset_rd0 got %h/%b exp 00/0", d, e); end
        apb_read(3'd1, d, e);
        n_tests++; if (d !== 8'd0) begin n_fail++; $display("FAIL reset_rd1 got %h exp 00", d); end
    endtask

    task automatic test_bit_period();
        logic [7:0] d; logic e;
        apb_write(3'd2, 8'h34, e);
        n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL bp_lo_err got %b exp 0", e); end
        apb_write(3'd3, 8'hFF, e);
        n_tests++; if (bit_period !== 14'h3F34) begin n_fail++; $display("FAIL bp_value got %h exp 3f34", bit_period); end
        apb_read(3'd3, d, e);
        n_tests++; if (d !== 8'h3F || e !== 1'b0) begin n_fail++; $display("FAIL bp_hi_rd got %h/%b exp 3f/0", d, e); end
        apb_read(3'd2, d, e);
        n_tests++; if (d !== 8'h34) begin n_fail++; $display("FAIL bp_lo_rd got %h exp 34", d); end
    endtask

    task automatic test_data_size();
        logic [7:0] d; logic e;
        apb_write(3'd4, 8'd9, e);
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL dsize9_err got %b exp 1", e); end
        n_tests++; if (data_size !== 4'd8) begin n_fail++; $display("FAIL dsize9_keep got %0d exp 8", data_size); end
        apb_write(3'd4, 8'd4, e);
        n_tests++; if (e !== 1'b1 || data_size !== 4'd8) begin n_fail++; $display("FAIL dsize4 got %b/%0d exp 1/8", e, data_size); end
        apb_write(3'd4, 8'd5, e);
        n_tests++; if (e !== 1'b0 || data_size !== 4'd5) begin n_fail++; $display("FAIL dsize5 got %b/%0d exp 0/5", e, data_size); end
        apb_read(3'd4, d, e);
        n_tests++; if (d !== 8'd5) begin n_fail++; $display("FAIL dsize_rd got %h exp 05", d); end
        apb_write(3'd4, 8'd8, e);
        n_tests++; if (e !== 1'b0 || data_size !== 4'd8) begin n_fail++; $display("FAIL dsize8 got %b/%0d exp 0/8", e, data_size); end
    endtask

    task automatic test_ro_writes();
        logic [7:0] d; logic e;
        apb_write(3'd0, 8'hFF, e);
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL wr0_err got %b exp 1", e); end
        apb_write(3'd5, 8'hFF, e);
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL wr5_err got %b exp 1", e); end
        apb_write(3'd6, 8'hFF, e);
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL wr6_err got %b exp 1", e); end
        apb_read(3'd5, d, e);
        n_tests++; if (d !== 8'd0) begin n_fail++; $display("FAIL wr5_noeffect got %h exp 00", d); end
`ifndef UART_RX_IRQ_EN
        apb_write(3'd7, 8'h03, e);
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL wr7_err got %b exp 1", e); end
        apb_read(3'd7, d, e);
        n_tests++; if (d !== 8'd0 || e !== 1'b1) begin n_fail++; $display("FAIL rd7 got %h/%b exp 00/1", d, e); end
`endif
    endtask

    task automatic test_fifo_basic();
        logic [7:0] d; logic e; int p;
        push_byte(8'hA5, p);
        n_tests++; if (p != 1) begin n_fail++; $display("FAIL push_a5_ack got %0d exp 1", p); end
        push_byte(8'h5A, p);
        n_tests++; if (p != 1) begin n_fail++; $display("FAIL push_5a_ack got %0d exp 1", p); end
        apb_read(3'd5, d, e);
        n_tests++; if (d !== 8'd2) begin n_fail++; $display("FAIL count2 got %h exp 02", d); end
        apb_read(3'd0, d, e);
        n_tests++; if (d !== 8'h01) begin n_fail++; $display("FAIL status_ne got %h exp 01", d); end
        apb_read(3'd6, d, e);
        n_tests++; if (d !== 8'hA5 || e !== 1'b0) begin n_fail++; $display("FAIL pop1 got %h/%b exp a5/0", d, e); end
        apb_read(3'd6, d, e);
        n_tests++; if (d !== 8'h5A || e !== 1'b0) begin n_fail++; $display("FAIL pop2 got %h/%b exp 5a/0", d, e); end
        apb_read(3'd6, d, e);
        n_tests++; if (d !== 8'h00 || e !== 1'b1) begin n_fail++; $display("FAIL pop_empty got %h/%b exp 00/1", d, e); end
        apb_read(3'd5, d, e);
        n_tests++; if (d !== 8'd0) begin n_fail++; $display("FAIL count0 got %h exp 00", d); end
    endtask

    task automatic test_overflow();
        logic [7:0] d; logic e; int p; int total;
        total = 0;
        for (int i = 0; i < 9; i++) begin
            push_byte(8'h10 + 8'(i), p);
            total += p;
        end
        n_tests++; if (total != 9) begin n_fail++; $display("FAIL ovf_acks got %0d exp 9", total); end
        apb_read(3'd0, d, e);
        n_tests++; if (d !== 8'h03) begin n_fail++; $display("FAIL ovf_status got %h exp 03", d); end
        apb_read(3'd5, d, e);
        n_tests++; if (d !== 8'd8) begin n_fail++; $display("FAIL ovf_count got %h exp 08", d); end
        apb_read(3'd1, d, e);
        n_tests++; if (d !== 8'h04) begin n_fail++; $display("FAIL ovf_flag got %h exp 04", d); end
        apb_write(3'd1, 8'h04, e);
        apb_read(3'd1, d, e);
        n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL ovf_w1c got %h exp 00", d); end
        for (int i = 0; i < 8; i++) begin
            apb_read(3'd6, d, e);
            n_tests++; if (d !== (8'h10 + 8'(i)) || e !== 1'b0) begin n_fail++; $display("FAIL ovf_pop%0d got %h/%b exp %h/0", i, d, e, 8'h10 + 8'(i)); end
        end
        apb_read(3'd6, d, e);
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL ovf_drop got err %b exp 1", e); end
    endtask

    task automatic test_errors();
        logic [7:0] d; logic e;
        framing_error = 1'b1; @(posedge clk); #1 framing_error = 1'b0;
        apb_read(3'd1, d, e);
        n_tests++; if (d !== 8'h01) begin n_fail++; $display("FAIL err_framing got %h exp 01", d); end
        overrun_error = 1'b1; @(posedge clk); #1 overrun_error = 1'b0;
        apb_read(3'd1, d, e);
        n_tests++; if (d !== 8'h03) begin n_fail++; $display("FAIL err_overrun got %h exp 03", d); end
        apb_write(3'd1, 8'h01, e);
        apb_read(3'd1, d, e);
        n_tests++; if (d !== 8'h02 || e !== 1'b0) begin n_fail++; $display("FAIL err_w1c0 got %h/%b exp 02/0", d, e); end
        framing_error = 1'b1;
        apb_write(3'd1, 8'h01, e);
        framing_error = 1'b0;
        apb_read(3'd1, d, e);
        n_tests++; if (d !== 8'h03) begin n_fail++; $display("FAIL err_set_wins got %h exp 03", d); end
        apb_write(3'd1, 8'h07, e);
        apb_read(3'd1, d, e);
        n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL err_clr_all got %h exp 00", d); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d; logic e; int p;
        for (int i = 0; i < 8; i++) push_byte(8'h20 + 8'(i), p);
        // Pop and push land on the same edge while full.
        psel = 1'b1; paddr = 3'd6; pwrite = 1'b0; penable = 1'b0;
        @(posedge clk); #1 penable = 1'b1; rx_data = 8'h99; data_ready = 1'b1;
        @(negedge clk); d = prdata; e = pslverr;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
        n_tests++; if (d !== 8'h20 || e !== 1'b0) begin n_fail++; $display("FAIL b2b_pop got %h/%b exp 20/0", d, e); end
        n_tests++; if (data_read !== 1'b1) begin n_fail++; $display("FAIL b2b_ack got %b exp 1", data_read); end
        data_ready = 1'b0;
        apb_read(3'd5, d, e);
        n_tests++; if (d !== 8'd8) begin n_fail++; $display("FAIL b2b_count got %h exp 08", d); end
        apb_read(3'd1, d, e);
        n_tests++; if (d !== 8'h00) begin n_fail++; $display("FAIL b2b_no_ovf got %h exp 00", d); end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp_b;
            exp_b = (i == 7) ? 8'h99 : (8'h21 + 8'(i));
            apb_read(3'd6, d, e);
            n_tests++; if (d !== exp_b) begin n_fail++; $display("FAIL b2b_pop%0d got %h exp %h", i, d, exp_b); end
        end
    endtask

    task automatic test_irq();
        logic [7:0] d; logic e; int p;
`ifdef UART_RX_IRQ_EN
        apb_write(3'd7, 8'h01, e);
        apb_read(3'd7, d, e);
        n_tests++; if (d !== 8'h01 || e !== 1'b0) begin n_fail++; $display("FAIL irqen_rd got %h/%b exp 01/0", d, e); end
        rx_data = 8'h42; data_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early got %b exp 0", irq); end
        data_ready = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set got %b exp 1", irq); end
        apb_read(3'd6, d, e);
        n_tests++; if (d !== 8'h42) begin n_fail++; $display("FAIL irq_pop got %h exp 42", d); end
        @(posedge clk); #1;
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clr got %b exp 0", irq); end
        apb_write(3'd7, 8'h00, e);
`else
        push_byte(8'h42, p);
        repeat (2) @(posedge clk); #1;
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_tied got %b exp 0", irq); end
        apb_read(3'd6, d, e);
        n_tests++; if (d !== 8'h42) begin n_fail++; $display("FAIL irq_pop got %h exp 42", d); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [7:0] d; logic e; int p;
        apb_write(3'd4, 8'd6, e);
        push_byte(8'h77, p);
        overrun_error = 1'b1; @(posedge clk); #1 overrun_error = 1'b0;
        // Reset lands on the same edge as a new data_ready rise.
        rst = 1'b1; rx_data = 8'h88; data_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (data_read !== 1'b0) begin n_fail++; $display("FAIL rst_ack_cancel got %b exp 0", data_read); end
        data_ready = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        n_tests++; if (data_size !== 4'd8 || bit_period !== 14'd0) begin n_fail++; $display("FAIL rst_cfg got %0d/%h exp 8/0", data_size, bit_period); end
        apb_read(3'd5, d, e);
        n_tests++; if (d !== 8'd0) begin n_fail++; $display("FAIL rst_count got %h exp 00", d); end
        apb_read(3'd1, d, e);
        n_tests++; if (d !== 8'd0) begin n_fail++; $display("FAIL rst_errs got %h exp 00", d); end
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'd0; data_ready = 1'b0;
        overrun_error = 1'b0; framing_error = 1'b0;
        psel = 1'b0; paddr = 3'd0; penable = 1'b0; pwrite = 1'b0; pwdata = 8'd0;
        @(posedge clk); #1;
        test_reset();
        test_bit_period();
        test_data_size();
        test_ro_writes();
        test_fifo_basic();
        test_overflow();
        test_errors();
        test_back_to_back();
        test_irq();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_uart_rx_fifo_slave.md
Name: apb_uart_rx_fifo_slave

Overview:
Next-generation APB register slave for the UART receiver. Adds a parametrised receive FIFO between the receiver and the bus, plus sticky error flags with write-1-to-clear. Adds write validation with pslverr, a configurable bit-period width, and an optional interrupt. Sits between the APB interconnect and the rcv_block; drives bit_period/data_size to the receiver and acknowledges each received byte via data_read.

Parameters:
FIFO_DEPTH, 8, receive FIFO entries; power of two, 2..64
BP_W, 14, bit_period width; 9..16
CNT_W, $clog2(FIFO_DEPTH)+1, FIFO occupancy counter width (derived, not overridden)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
rx_data  in  8  received byte from receiver
data_ready  in  1  receiver has a byte; held high until acknowledged
overrun_error  in  1  receiver overrun indication
framing_error  in  1  receiver framing error indication
psel  in  1  APB select
paddr  in  3  APB address
penable  in  1  APB access phase
pwrite  in  1  APB write
pwdata  in  8  APB write data
prdata  out  8  APB read data
pslverr  out  1  APB slave error
data_read  out  1  one-cycle acknowledge to receiver
data_size  out  4  character length to receiver
bit_period  out  BP_W  clocks per bit to receiver
irq  out  1  interrupt (tied 0 unless UART_RX_IRQ_EN)

Behaviour:
- Reset (rst=1 at clk edge): FIFO empty, count 0, error flags 0, bit_period 0, data_size 4'd8, data_read 0, irq 0, internal data_ready history 0. prdata/pslverr are combinational and read 0 when no access is in progress.
- Access phase = psel&penable. prdata and pslverr are combinational in the access phase and 0 otherwise. Register updates and FIFO pops take effect at the clk edge ending the access phase.
- Register map:
  - 0 RO status: bit0 = not empty, bit1 = full, rest 0.
  - 1 RW errors: bit0 framing, bit1 receiver overrun, bit2 FIFO overflow. Write 1 clears that bit.
  - 2 RW bit_period[7:0].
  - 3 RW bit_period[BP_W-1:8]; unused bits read 0 and ignore writes.
  - 4 RW data_size. Only 5..8 are legal. Any other value: pslverr=1, register unchanged.
  - 5 RO FIFO count, zero-extended.
  - 6 RO FIFO head. A read pops the FIFO. Read while empty: prdata=0, pslverr=1, no pop.
  - 7 reserved: prdata=0, pslverr=1.
- Any write to 0, 5 or 6: pslverr=1, no effect.
- Push: a byte is pushed on the cycle data_ready is high and was low the previous cycle (rising-edge detect). data_read=1 the next cycle for exactly one cycle.
- Push while full: byte is dropped, error bit2 is set, and data_read still pulses so the receiver is released.
- Error flags: framing and overrun are sampled every cycle. Bit0 is set on any cycle framing_error=1; bit1 is set on any cycle overrun_error=1.
- If a set and a W1C clear of the same bit occur in one cycle, the set wins.
- Simultaneous push and pop: both occur, count unchanged. This holds when full, so no overflow occurs.
- Pop and push pointers wrap modulo FIFO_DEPTH. Count is exact in 0..FIFO_DEPTH.
- Status and count are registered. A byte pushed on edge N is visible to a read in the cycle after edge N.
- rst asserted mid-transfer: all state returns to reset values at that edge, and an in-flight data_read pulse is cancelled.

Optional Feature:
- Macro: UART_RX_IRQ_EN.
- When defined, address 7 is RW irq_enable: bit0 = FIFO not empty, bit1 = any error flag set, reset 0. irq is registered and equals the OR of enabled active conditions, updating one cycle after the condition changes.
- When undefined, irq is constant 0 and address 7 is reserved as above.

Test Plan:
- Reset then read addr 4 -> prdata=8. Read addr 0 -> 0. bit_period=0. data_read=0.
- Write addr2=0x34, addr3=0xFF (BP_W=14) -> bit_period=14'h3F34. Read addr3 -> 0x3F.
- Write addr4=9 -> pslverr=1, data_size stays 8. Write addr4=5 -> pslverr=0, data_size=5.
- Push 0xA5 then 0x5A via data_ready pulses -> each gives one data_read pulse. Count=2. Read addr6 returns 0xA5 then 0x5A, then a third read gives pslverr=1 with prdata=0.
- Push 9 bytes with FIFO_DEPTH=8 -> status full, error bit2=1, 9th byte dropped, 9 data_read pulses. Write addr1=0x04 -> bit2 clears.
- UART_RX_IRQ_EN: write addr7=0x01, push one byte -> irq=1 one cycle after count becomes 1. Pop -> irq=0.
